// File: rtl/vc_dest_arbiter.sv
// vc_dest_arbiter: pops words from the VC0/VC1 FIFOs and routes each one to
// the D0 or D1 destination FIFO according to the word's MSB.
// Optional feature: define VC_ARB_RR_EN for round-robin VC arbitration;
// otherwise VC0 has strict priority over VC1.
// state_dbg exposes the control state: 0=IDLE, 1=ARB, 2=HOLD.
// Handshake: a pop strobe (vcX_read) is issued combinationally only in ARB
// with active=1, both almost_full flags low and the chosen VC non-empty; the
// popped word appears on vcX_data after the edge and is pushed (dX_write)
// two cycles after the pop, unconditionally, even into a full destination.
module vc_dest_arbiter #(
  parameter int DATA_SIZE = 6,
  parameter int CNT_SIZE  = 8
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 active,
  input  logic                 vc0_empty,
  input  logic                 vc1_empty,
  input  logic [DATA_SIZE-1:0] vc0_data,
  input  logic [DATA_SIZE-1:0] vc1_data,
  output logic                 vc0_read,
  output logic                 vc1_read,
  input  logic                 d0_almost_full,
  input  logic                 d1_almost_full,
  input  logic                 d0_full,
  input  logic                 d1_full,
  output logic                 d0_write,
  output logic                 d1_write,
  output logic [DATA_SIZE-1:0] d0_data,
  output logic [DATA_SIZE-1:0] d1_data,
  output logic [CNT_SIZE-1:0]  d0_count,
  output logic [CNT_SIZE-1:0]  d1_count,
  output logic                 error_out,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 src_valid_q, src_valid_d;
  logic                 src_id_q, src_id_d;
  logic                 d0_write_q, d0_write_d;
  logic                 d1_write_q, d1_write_d;
  logic [DATA_SIZE-1:0] d0_data_q, d0_data_d;
  logic [DATA_SIZE-1:0] d1_data_q, d1_data_d;
  logic [CNT_SIZE-1:0]  d0_count_q, d0_count_d;
  logic [CNT_SIZE-1:0]  d1_count_q, d1_count_d;
  logic                 error_q, error_d;
  logic                 any_afull;
  logic                 pop_ok;
  logic [DATA_SIZE-1:0] word;
  logic                 dest;

  assign any_afull = d0_almost_full | d1_almost_full;
  assign pop_ok    = (state_q == ARB) && active && !any_afull;

`ifdef VC_ARB_RR_EN
  logic rr_ptr_q, rr_ptr_d;

  // Round-robin pop select: pointed VC first, the other one if it is empty
  always_comb begin
    vc0_read = 1'b0;
    vc1_read = 1'b0;
    if (pop_ok) begin
      if (!rr_ptr_q) begin
        if (!vc0_empty)      vc0_read = 1'b1;
        else if (!vc1_empty) vc1_read = 1'b1;
      end else begin
        if (!vc1_empty)      vc1_read = 1'b1;
        else if (!vc0_empty) vc0_read = 1'b1;
      end
    end
    rr_ptr_d = rr_ptr_q ^ (vc0_read | vc1_read);
  end

  // Pointer flips after every pop, whichever VC was served
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) rr_ptr_q <= 1'b0;
    else          rr_ptr_q <= rr_ptr_d;
  end
`else
  // Strict-priority pop select: VC0 always wins when it has data
  always_comb begin
    vc0_read = 1'b0;
    vc1_read = 1'b0;
    if (pop_ok) begin
      if (!vc0_empty)      vc0_read = 1'b1;
      else if (!vc1_empty) vc1_read = 1'b1;
    end
  end
`endif

  // Control FSM next state: leaving ARB/HOLD on active=0 takes precedence
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (active) state_d = ARB;
      ARB: begin
        if (!active)        state_d = IDLE;
        else if (any_afull) state_d = HOLD;
      end
      HOLD: begin
        if (!active)         state_d = IDLE;
        else if (!any_afull) state_d = ARB;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pipeline: record the pop, then route the FIFO's registered word
  always_comb begin
    src_valid_d = vc0_read | vc1_read;
    src_id_d    = vc1_read;
    word        = src_id_q ? vc1_data : vc0_data;
    dest        = word[DATA_SIZE-1];
    d0_write_d  = src_valid_q & ~dest;
    d1_write_d  = src_valid_q & dest;
    d0_data_d   = d0_write_d ? word : d0_data_q;
    d1_data_d   = d1_write_d ? word : d1_data_q;
    d0_count_d  = d0_count_q + {{(CNT_SIZE-1){1'b0}}, d0_write_d};
    d1_count_d  = d1_count_q + {{(CNT_SIZE-1){1'b0}}, d1_write_d};
    error_d     = error_q | (d0_write_d & d0_full) | (d1_write_d & d1_full);
  end

  // State, pipeline and output registers; reset drops in-flight words
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      src_valid_q <= 1'b0;
      src_id_q    <= 1'b0;
      d0_write_q  <= 1'b0;
      d1_write_q  <= 1'b0;
      d0_data_q   <= '0;
      d1_data_q   <= '0;
      d0_count_q  <= '0;
      d1_count_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_valid_q <= src_valid_d;
      src_id_q    <= src_id_d;
      d0_write_q  <= d0_write_d;
      d1_write_q  <= d1_write_d;
      d0_data_q   <= d0_data_d;
      d1_data_q   <= d1_data_d;
      d0_count_q  <= d0_count_d;
      d1_count_q  <= d1_count_d;
      error_q     <= error_d;
    end
  end

  assign d0_write  = d0_write_q;
  assign d1_write  = d1_write_q;
  assign d0_data   = d0_data_q;
  assign d1_data   = d1_data_q;
  assign d0_count  = d0_count_q;
  assign d1_count  = d1_count_q;
  assign error_out = error_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Bench for vc_dest_arbiter: FSM/gating vector table, directed sequences and
// randomized traffic checked against a queue-based reference model.
module tb_vc_dest_arbiter;
  localparam int DW = 6;
  localparam int CW = 8;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          active = 1'b0;
  logic          vc0_empty = 1'b1, vc1_empty = 1'b1;
  logic [DW-1:0] vc0_data = '0, vc1_data = '0;
  logic          vc0_read, vc1_read;
  logic          d0_almost_full = 1'b0, d1_almost_full = 1'b0;
  logic          d0_full = 1'b0, d1_full = 1'b0;
  logic          d0_write, d1_write;
  logic [DW-1:0] d0_data, d1_data;
  logic [CW-1:0] d0_count, d1_count;
  logic          error_out;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  vc_dest_arbiter #(.DATA_SIZE(DW), .CNT_SIZE(CW)) dut (
    .clk(clk), .reset_L(reset_L), .active(active),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .vc0_read(vc0_read), .vc1_read(vc1_read),
    .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
    .d0_full(d0_full), .d1_full(d1_full),
    .d0_write(d0_write), .d1_write(d1_write),
    .d0_data(d0_data), .d1_data(d1_data),
    .d0_count(d0_count), .d1_count(d1_count),
    .error_out(error_out), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // VC FIFO contents (front = next word the FIFO will present)
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  // Words popped but not yet pushed, with the cycle their push must appear in
  typedef struct {
    int            due;
    logic [DW-1:0] w;
    logic          err;
  } pend_t;
  pend_t pend[$];

  int            m_state;   // 0 idle, 1 arbitrating, 2 holding
  logic          m_ptr;     // round-robin preference (0 = VC0)
  logic [DW-1:0] m_d0, m_d1;
  int            m_c0, m_c1;
  logic          m_err;
  int            n_writes;
  int            last_w0, last_w1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_vc();
    vc0_empty = (q0.size() == 0);
    vc1_empty = (q1.size() == 0);
  endtask

  task automatic m_clear();
    q0.delete(); q1.delete(); pend.delete();
    m_state = 0; m_ptr = 1'b0;
    m_d0 = '0; m_d1 = '0; m_c0 = 0; m_c1 = 0; m_err = 1'b0;
    vc0_data = '0; vc1_data = '0;
    drive_vc();
  endtask

  // One clock cycle: compare at negedge, advance the model, then let the
  // VC FIFOs present the popped word just after the rising edge.
  task automatic cycle();
    int            exp_pop;
    int            first;
    logic          w0, w1;
    logic [DW-1:0] wd;
    @(negedge clk);
    w0 = 1'b0; w1 = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      pend_t e;
      e = pend.pop_front();
      if (e.w[DW-1]) begin w1 = 1'b1; m_d1 = e.w; m_c1 = (m_c1 + 1) % (1 << CW); end
      else           begin w0 = 1'b1; m_d0 = e.w; m_c0 = (m_c0 + 1) % (1 << CW); end
      if (e.err) m_err = 1'b1;
    end
    exp_pop = -1;
    if (reset_L && m_state == 1 && active && !d0_almost_full && !d1_almost_full) begin
`ifdef VC_ARB_RR_EN
      first = m_ptr ? 1 : 0;
`else
      first = 0;
`endif
      if (first == 0) exp_pop = (q0.size() > 0) ? 0 : ((q1.size() > 0) ? 1 : -1);
      else            exp_pop = (q1.size() > 0) ? 1 : ((q0.size() > 0) ? 0 : -1);
    end
    chk("vc0_read", vc0_read, exp_pop == 0);
    chk("vc1_read", vc1_read, exp_pop == 1);
    chk("d0_write", d0_write, w0);
    chk("d1_write", d1_write, w1);
    chk("d0_data", d0_data, m_d0);
    chk("d1_data", d1_data, m_d1);
    chk("d0_count", d0_count, m_c0);
    chk("d1_count", d1_count, m_c1);
    chk("error_out", error_out, m_err);
    chk("state", state_dbg, m_state);
    if (d0_write === 1'b1) begin n_writes++; last_w0 = cyc; end
    if (d1_write === 1'b1) begin n_writes++; last_w1 = cyc; end
    // schedule the popped word two cycles out
    if (exp_pop >= 0) begin
      wd = (exp_pop == 0) ? q0[0] : q1[0];
      pend.push_back('{due: cyc + 2, w: wd, err: 1'b0});
      m_ptr = ~m_ptr;
    end
    // a push decided this cycle errors if its destination is full now
    foreach (pend[i])
      if (pend[i].due == cyc + 1)
        pend[i].err = pend[i].w[DW-1] ? d1_full : d0_full;
    // control state progression
    if (!reset_L) m_state = 0;
    else case (m_state)
      0: if (active) m_state = 1;
      1: if (!active) m_state = 0; else if (d0_almost_full || d1_almost_full) m_state = 2;
      2: if (!active) m_state = 0; else if (!d0_almost_full && !d1_almost_full) m_state = 1;
      default: m_state = 0;
    endcase
    @(posedge clk);
    #1;
    if (exp_pop == 0) vc0_data = q0.pop_front();
    if (exp_pop == 1) vc1_data = q1.pop_front();
    drive_vc();
    cyc++;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    active = 1'b0;
    d0_almost_full = 1'b0; d1_almost_full = 1'b0;
    d0_full = 1'b0; d1_full = 1'b0;
    m_clear();
    repeat (2) cycle();
    reset_L = 1'b1;
  endtask

  // ---------------- FSM / gating vector table ----------------
  typedef struct {
    logic       act, af0, af1, e0, e1;
    logic       r0, r1;
    logic [1:0] st;
  } vec_t;
  vec_t tbl[15];

  initial begin
    logic [DW-1:0] w;
    int            t0;

    //           act af0 af1 e0 e1  r0 r1 state
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 2'd0};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0, 2'd0};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0, 2'd1};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1, 2'd1};
    tbl[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0, 2'd1};
    tbl[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0, 2'd2};
    tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 2'd2};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0, 2'd1};
    tbl[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0, 2'd1};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 2'd1};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 2'd0};
    tbl[11] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0, 2'd0};
    tbl[12] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0, 2'd1};
    tbl[13] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0, 2'd2};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0, 2'd0};

    // reset state
    m_clear();
    #1;
    chk("rst_state", state_dbg, 0);
    chk("rst_d0_write", d0_write, 0);
    chk("rst_error", error_out, 0);
    @(posedge clk); #1;
    reset_L = 1'b1;

    for (int i = 0; i < 15; i++) begin
      active = tbl[i].act; d0_almost_full = tbl[i].af0; d1_almost_full = tbl[i].af1;
      vc0_empty = tbl[i].e0; vc1_empty = tbl[i].e1;
      @(negedge clk);
      chk($sformatf("tbl%0d_vc0_read", i), vc0_read, tbl[i].r0);
      chk($sformatf("tbl%0d_vc1_read", i), vc1_read, tbl[i].r1);
      chk($sformatf("tbl%0d_state", i), state_dbg, tbl[i].st);
      @(posedge clk); #1;
    end

    // basic routing and latency: 0x05 -> D0, 0x25 -> D1
    do_reset();
    q0.push_back(6'h05); q0.push_back(6'h25); drive_vc();
    active = 1'b1;
    t0 = cyc; last_w0 = -1; last_w1 = -1;
    repeat (7) cycle();
    chk("t2_d0_cycle", last_w0 - t0, 3);
    chk("t2_d1_cycle", last_w1 - t0, 4);
    chk("t2_d0_count", d0_count, 1);
    chk("t2_d1_count", d1_count, 1);

    // priority / round-robin order with both VCs loaded
    do_reset();
    for (int i = 0; i < 4; i++) begin q0.push_back(6'(i)); q1.push_back(6'(6'h20 + i)); end
    drive_vc(); active = 1'b1;
    repeat (12) cycle();

    // reset with two words in flight
    do_reset();
    for (int i = 0; i < 6; i++) q0.push_back(6'(6'h08 + i));
    drive_vc(); active = 1'b1;
    repeat (3) cycle();
    reset_L = 1'b0; m_clear();
    n_writes = 0;
    repeat (2) cycle();
    reset_L = 1'b1;
    repeat (5) cycle();
    chk("t1_no_writes", n_writes, 0);
    chk("t1_d0_count", d0_count, 0);
    chk("t1_error", error_out, 0);

    // almost_full mid-stream, then full at a D0 push edge
    do_reset();
    for (int i = 0; i < 10; i++) q0.push_back(6'($urandom_range(0, 63)));
    drive_vc(); active = 1'b1;
    repeat (4) cycle();
    d1_almost_full = 1'b1;
    repeat (3) cycle();
    d1_almost_full = 1'b0;
    repeat (2) cycle();
    do_reset();
    q0.push_back(6'h11); drive_vc(); active = 1'b1;
    repeat (2) cycle();
    d0_full = 1'b1;
    cycle();
    d0_full = 1'b0;
    repeat (4) cycle();
    chk("t5_error_sticky", error_out, 1);
    chk("t5_d0_count", d0_count, 1);

    // counter wrap: 256 words into D0
    do_reset();
    for (int i = 0; i < 256; i++) q0.push_back(6'($urandom_range(0, 31)));
    drive_vc(); active = 1'b1;
    repeat (262) cycle();
    chk("t6_d0_wrap", d0_count, 0);
    active = 1'b0;
    q0.push_back(6'h01); drive_vc();
    repeat (3) cycle();
    chk("t6_idle_state", state_dbg, 0);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (q0.size() < 8 && $urandom_range(0, 99) < 40) q0.push_back(6'($urandom_range(0, 63)));
      if (q1.size() < 8 && $urandom_range(0, 99) < 40) q1.push_back(6'($urandom_range(0, 63)));
      drive_vc();
      active = ($urandom_range(0, 99) < 90);
      d0_almost_full = ($urandom_range(0, 99) < 12);
      d1_almost_full = ($urandom_range(0, 99) < 12);
      d0_full = ($urandom_range(0, 99) < 2);
      d1_full = ($urandom_range(0, 99) < 2);
      cycle();
    end
    active = 1'b0; d0_almost_full = 1'b0; d1_almost_full = 1'b0;
    d0_full = 1'b0; d1_full = 1'b0;
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
